// File: rtl/cfg_bitstream_loader.sv
// Serial configuration front-end: hunts for the sync word, collects payload and checksum bytes,
// and commits the payload to the fabric's bitfile bus only when the frame checksum is good.
module cfg_bitstream_loader #(
   parameter logic [7:0]  SYNC_WORD   = 8'hA5,
   parameter logic [7:0]  DEFAULT_CFG = 8'h00,
   parameter int unsigned TIMEOUT     = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cfg_bit_valid,
   input  logic       cfg_bit,
   output logic [7:0] bitfile,
   output logic       cfg_loaded,
   output logic       cfg_error,
   output logic       cfg_busy,
   output logic       cfg_valid
);

   localparam logic [1:0] ST_HUNT     = 2'd0;
   localparam logic [1:0] ST_PAYLOAD  = 2'd1;
   localparam logic [1:0] ST_CHECKSUM = 2'd2;

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   logic [1:0] state_q, state_d;
   logic [7:0] win_q, win_d;
   logic [3:0] hcnt_q, hcnt_d;
   logic [2:0] idx_q, idx_d;
   logic [7:0] payload_q, payload_d;
   logic [7:0] chk_q, chk_d;
   logic [7:0] idle_q, idle_d;
   logic [7:0] bitfile_q, bitfile_d;
   logic       loaded_q, loaded_d;
   logic       error_q, error_d;
   logic       busy_q, busy_d;
   logic       valid_q, valid_d;
   logic [7:0] sum;
   logic       abort;

   always_comb begin
      state_d   = state_q;
      win_d     = win_q;
      hcnt_d    = hcnt_q;
      idx_d     = idx_q;
      payload_d = payload_q;
      chk_d     = chk_q;
      idle_d    = idle_q;
      bitfile_d = bitfile_q;
      valid_d   = valid_q;
      loaded_d  = 1'b0;
      error_d   = 1'b0;
      abort     = 1'b0;
      sum       = 8'h00;

      unique case (state_q)
         ST_HUNT: begin
            idle_d = 8'h00;
            if (cfg_bit_valid) begin
               win_d = {win_q[6:0], cfg_bit};
               if (hcnt_q != 4'd8) hcnt_d = hcnt_q + 4'd1;
               if (hcnt_d >= 4'd8 && win_d == SYNC_WORD) begin
                  state_d = ST_PAYLOAD;
                  idx_d   = 3'd0;
               end
            end
         end
         ST_PAYLOAD, ST_CHECKSUM: begin
            if (cfg_bit_valid) begin
               idle_d = 8'h00;
               idx_d  = idx_q + 3'd1;
               if (state_q == ST_PAYLOAD) begin
                  payload_d = {payload_q[6:0], cfg_bit};
                  if (idx_q == 3'd7) state_d = ST_CHECKSUM;
               end else begin
                  chk_d = {chk_q[6:0], cfg_bit};
                  if (idx_q == 3'd7) begin
                     // Final checksum bit is folded in combinationally at its sampling edge.
                     sum = SYNC_WORD + payload_q + chk_d;
                     if (sum == 8'h00) begin
                        bitfile_d = payload_q;
                        loaded_d  = 1'b1;
                        valid_d   = 1'b1;
                     end else begin
                        error_d = 1'b1;
                     end
                     abort = 1'b1;
                  end
               end
            end else begin
               idle_d = idle_q + 8'd1;
               if (idle_d == TIMEOUT_CNT) begin
                  error_d = 1'b1;
                  abort   = 1'b1;
               end
            end
         end
         default: abort = 1'b1;
      endcase

      if (abort) begin
         state_d   = ST_HUNT;
         win_d     = 8'h00;
         hcnt_d    = 4'd0;
         idx_d     = 3'd0;
         payload_d = 8'h00;
         chk_d     = 8'h00;
         idle_d    = 8'h00;
      end

      busy_d = (state_d != ST_HUNT);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_HUNT;
         win_q     <= 8'h00;
         hcnt_q    <= 4'd0;
         idx_q     <= 3'd0;
         payload_q <= 8'h00;
         chk_q     <= 8'h00;
         idle_q    <= 8'h00;
         bitfile_q <= DEFAULT_CFG;
         loaded_q  <= 1'b0;
         error_q   <= 1'b0;
         busy_q    <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         win_q     <= win_d;
         hcnt_q    <= hcnt_d;
         idx_q     <= idx_d;
         payload_q <= payload_d;
         chk_q     <= chk_d;
         idle_q    <= idle_d;
         bitfile_q <= bitfile_d;
         loaded_q  <= loaded_d;
         error_q   <= error_d;
         busy_q    <= busy_d;
         valid_q   <= valid_d;
      end
   end

   assign bitfile    = bitfile_q;
   assign cfg_loaded = loaded_q;
   assign cfg_error  = error_q;
   assign cfg_busy   = busy_q;
   assign cfg_valid  = valid_q;

endmodule

// File: tb/tb_cfg_bitstream_loader.sv
// Bench for cfg_bitstream_loader: directed frames from the test plan plus randomized frames,
// checked every cycle against a frame-level reference model built on bit queues.
module tb_cfg_bitstream_loader;

   localparam int TIMEOUT = 64;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       cfg_bit_valid = 1'b0;
   logic       cfg_bit = 1'b0;
   logic [7:0] bitfile;
   logic       cfg_loaded, cfg_error, cfg_busy, cfg_valid;

   cfg_bitstream_loader #(
      .SYNC_WORD  (8'hA5),
      .DEFAULT_CFG(8'h00),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .cfg_bit_valid(cfg_bit_valid),
      .cfg_bit      (cfg_bit),
      .bitfile      (bitfile),
      .cfg_loaded   (cfg_loaded),
      .cfg_error    (cfg_error),
      .cfg_busy     (cfg_busy),
      .cfg_valid    (cfg_valid)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int n_busy, n_loaded, n_error;

   // Reference model state: frame-level view.
   logic [7:0] m_bitfile;
   logic       m_valid, m_loaded, m_error, m_inframe;
   int         m_idle;
   logic       hist[$];
   logic       fq[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] q_byte(input int start);
      logic [7:0] r = 8'h00;
      for (int i = 0; i < 8; i++) r = {r[6:0], fq[start + i]};
      return r;
   endfunction

   task automatic model_reset();
      m_bitfile = 8'h00;
      m_valid   = 1'b0;
      m_loaded  = 1'b0;
      m_error   = 1'b0;
      m_inframe = 1'b0;
      m_idle    = 0;
      hist.delete();
      fq.delete();
   endtask

   task automatic model_end_frame();
      m_inframe = 1'b0;
      m_idle    = 0;
      hist.delete();
      fq.delete();
   endtask

   task automatic model_update(input logic v, input logic b);
      logic [7:0] last8;
      int p, c;
      m_loaded = 1'b0;
      m_error  = 1'b0;
      if (!m_inframe) begin
         if (v) begin
            hist.push_back(b);
            if (hist.size() > 8) void'(hist.pop_front());
            if (hist.size() == 8) begin
               for (int i = 0; i < 8; i++) last8 = {last8[6:0], hist[i]};
               if (last8 == 8'hA5) begin
                  m_inframe = 1'b1;
                  m_idle    = 0;
                  fq.delete();
               end
            end
         end
      end else if (v) begin
         m_idle = 0;
         fq.push_back(b);
         if (fq.size() == 16) begin
            p = q_byte(0);
            c = q_byte(8);
            if ((165 + p + c) % 256 == 0) begin
               m_bitfile = 8'(p);
               m_valid   = 1'b1;
               m_loaded  = 1'b1;
            end else begin
               m_error = 1'b1;
            end
            model_end_frame();
         end
      end else begin
         m_idle++;
         if (m_idle == TIMEOUT) begin
            m_error = 1'b1;
            model_end_frame();
         end
      end
   endtask

   task automatic step(input logic v, input logic b);
      cfg_bit_valid = v;
      cfg_bit       = b;
      @(posedge clk);
      model_update(v, b);
      @(negedge clk);
      check_eq("bitfile", 32'(bitfile), 32'(m_bitfile));
      check_eq("cfg_loaded", 32'(cfg_loaded), 32'(m_loaded));
      check_eq("cfg_error", 32'(cfg_error), 32'(m_error));
      check_eq("cfg_busy", 32'(cfg_busy), 32'(m_inframe));
      check_eq("cfg_valid", 32'(cfg_valid), 32'(m_valid));
      n_busy   += int'(cfg_busy);
      n_loaded += int'(cfg_loaded);
      n_error  += int'(cfg_error);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0);
   endtask

   task automatic send_bits(input logic [7:0] d, input int n, input bit gaps);
      for (int i = 7; i > 7 - n; i--) begin
         if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
         step(1'b1, d[i]);
      end
   endtask

   task automatic send_frame(input logic [7:0] p, input logic [7:0] c);
      send_bits(8'hA5, 8, 1'b0);
      send_bits(p, 8, 1'b0);
      send_bits(c, 8, 1'b0);
   endtask

   task automatic clear_counts();
      n_busy = 0;
      n_loaded = 0;
      n_error = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      cfg_bit_valid = 1'b0;
      #1;
      model_reset();
      check_eq("rst_bitfile", 32'(bitfile), 32'h00);
      check_eq("rst_valid", 32'(cfg_valid), 32'h0);
      check_eq("rst_busy", 32'(cfg_busy), 32'h0);
      check_eq("rst_loaded", 32'(cfg_loaded), 32'h0);
      check_eq("rst_error", 32'(cfg_error), 32'h0);
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      logic [7:0] p, c;
      model_reset();
      clear_counts();
      do_reset();
      idle(3);

      // Good frame, continuous
      clear_counts();
      send_frame(8'h1B, 8'h40);
      idle(2);
      check_eq("a_busy_len", 32'(n_busy), 32'd16);
      check_eq("a_loaded_cnt", 32'(n_loaded), 32'd1);
      check_eq("a_bitfile", 32'(bitfile), 32'h1B);
      check_eq("a_valid", 32'(cfg_valid), 32'h1);

      // Bad checksum
      clear_counts();
      send_frame(8'h1B, 8'h41);
      idle(2);
      check_eq("b_error_cnt", 32'(n_error), 32'd1);
      check_eq("b_loaded_cnt", 32'(n_loaded), 32'd0);
      check_eq("b_bitfile", 32'(bitfile), 32'h1B);
      check_eq("b_busy", 32'(cfg_busy), 32'h0);

      // Garbage prefix, sliding window
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      send_frame(8'h3C, 8'h1F);
      idle(1);
      check_eq("c_bitfile", 32'(bitfile), 32'h3C);

      // Gap of TIMEOUT-1 tolerated
      clear_counts();
      send_bits(8'hA5, 8, 1'b0);
      send_bits(8'h1B, 4, 1'b0);
      idle(TIMEOUT - 1);
      send_bits(8'hB0, 4, 1'b0);
      send_bits(8'h40, 8, 1'b0);
      idle(1);
      check_eq("d_loaded_cnt", 32'(n_loaded), 32'd1);
      check_eq("d_error_cnt", 32'(n_error), 32'd0);
      check_eq("d_bitfile", 32'(bitfile), 32'h1B);

      // Gap of TIMEOUT aborts on the last idle cycle
      clear_counts();
      send_bits(8'hA5, 8, 1'b0);
      send_bits(8'h3C, 4, 1'b0);
      idle(TIMEOUT - 1);
      check_eq("e_no_err_yet", 32'(n_error), 32'd0);
      idle(1);
      check_eq("e_err_now", 32'(cfg_error), 32'h1);
      check_eq("e_busy", 32'(cfg_busy), 32'h0);
      send_frame(8'h3C, 8'h1F);
      idle(1);
      check_eq("e_bitfile", 32'(bitfile), 32'h3C);

      // Reset mid-frame
      send_frame(8'h1B, 8'h40);
      send_bits(8'hA5, 8, 1'b0);
      send_bits(8'h77, 4, 1'b0);
      do_reset();
      send_frame(8'h3C, 8'h1F);
      idle(1);
      check_eq("f_bitfile", 32'(bitfile), 32'h3C);
      check_eq("f_valid", 32'(cfg_valid), 32'h1);

      // Randomized frames with garbage, gaps, bad checksums and occasional timeouts
      for (int n = 0; n < 150; n++) begin
         for (int g = $urandom_range(0, 10); g > 0; g--) step(1'b1, 1'($urandom_range(0, 1)));
         p = 8'($urandom_range(0, 255));
         c = 8'h00 - 8'hA5 - p;
         if ($urandom_range(0, 3) == 0) c = c ^ 8'($urandom_range(1, 255));
         send_bits(8'hA5, 8, 1'b1);
         send_bits(p, 8, 1'b1);
         if ($urandom_range(0, 9) == 0) idle($urandom_range(TIMEOUT - 4, TIMEOUT + 2));
         send_bits(c, 8, 1'b1);
         idle($urandom_range(0, 3));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cfg_bitstream_loader.md
# cfg_bitstream_loader

Serial configuration front-end for the 4-CLB fabric. It receives a bit-serial configuration stream, finds the frame sync word and collects the payload byte. It checks the frame checksum, then commits the byte to the 8-bit `bitfile` bus that drives the fabric's Controller (`bitfile_input` of the fabric top). The fabric sees only committed, checksum-verified configurations, and `bitfile` never changes mid-frame.

## Interface
- `SYNC_WORD`, 8'hA5: frame start marker, sent MSB first.
- `DEFAULT_CFG`, 8'h00: value of `bitfile` after reset.
- `TIMEOUT`, 64: number of consecutive idle cycles inside a frame that aborts it; legal range 2..255.
- `clk`  in  1: sole clock; all state changes on its rising edge.
- `reset`  in  1: asynchronous, active-low; low clears all state immediately.
- `cfg_bit_valid`  in  1: `cfg_bit` is sampled on this cycle's edge.
- `cfg_bit`  in  1: serial configuration data, MSB first per byte.
- `bitfile`  out  8: committed configuration byte, to the fabric's `bitfile_input`.
- `cfg_loaded`  out  1: one-cycle pulse when a frame commits.
- `cfg_error`  out  1: one-cycle pulse on a checksum mismatch or timeout.
- `cfg_busy`  out  1: high while a frame is being collected (PAYLOAD or CHECKSUM state).
- `cfg_valid`  out  1: sticky; high once any frame has committed since reset.

## Operation
- Frame format: SYNC_WORD, then payload byte P, then checksum byte C, 24 bits total, each byte MSB first.
- Checksum rule: the frame is good when (SYNC_WORD + P + C) mod 256 == 0, using an 8-bit wrap-around sum.
- FSM states: HUNT, PAYLOAD, CHECKSUM. Reset state is HUNT.
- HUNT:
  - Each valid bit shifts into an 8-bit window: win <= {win[6:0], cfg_bit}.
  - A saturating counter counts valid bits since entering HUNT.
  - When the counter reaches at least 8 and the updated window equals SYNC_WORD, go to PAYLOAD with bit index 0.
  - Matching uses a sliding window, so arbitrary garbage before the sync word is tolerated.
- PAYLOAD: 8 valid bits shift into a payload holding register. The 8th bit moves the FSM to CHECKSUM with bit index 0.
- CHECKSUM:
  - 8 valid bits are collected.
  - At the edge that samples the 8th bit, the sum is evaluated using that bit combinationally.
  - If good: `bitfile` <= P, `cfg_loaded` <= 1, `cfg_valid` <= 1.
  - If bad: `cfg_error` <= 1 and `bitfile` is unchanged.
  - In both cases the next state is HUNT with the window and counter cleared. Back-to-back frames need no gap.
- Timeout:
  - In PAYLOAD or CHECKSUM, an idle counter increments on every cycle with `cfg_bit_valid` low and clears on any valid bit.
  - When it reaches TIMEOUT: `cfg_error` <= 1, go to HUNT, clear the partial frame.
  - A gap of TIMEOUT-1 idle cycles is tolerated.
  - The counter is held at 0 in HUNT; HUNT never times out.
- `bitfile` is written only on a good commit. It stays stable during any collection, error or timeout.
- Reset values: `bitfile` = DEFAULT_CFG; `cfg_loaded`, `cfg_error`, `cfg_busy`, `cfg_valid` = 0.
- Reset also clears the FSM to HUNT and clears the window, counters and payload.
- Reset mid-frame discards the partial frame. A previously committed `bitfile` reverts to DEFAULT_CFG.

## Timing
- All outputs are registered.
- Latency: `bitfile`, `cfg_loaded` and `cfg_valid` update at the same edge that samples the final checksum bit, so they are visible in the following cycle.
- `cfg_loaded` and `cfg_error` are exactly one cycle wide and never high together.
- `cfg_busy` rises on the edge that matches the sync word. It falls on the commit, error or timeout edge.
- Minimum frame time is 24 cycles with `cfg_bit_valid` held high.
- If the timeout and the 8th checksum bit land in the same cycle, the valid bit wins: the idle count is cleared and the checksum is evaluated.

## Test plan
- Reset (`reset`=0, then 1) -> `bitfile`=8'h00; `cfg_valid`, `cfg_busy`, `cfg_loaded` and `cfg_error` all 0.
- Continuous stream A5, 1B, 40 -> `cfg_busy` high for 16 cycles; `bitfile`=8'h1B with a single-cycle `cfg_loaded`; `cfg_valid`=1.
- Stream A5, 1B, 41 -> single-cycle `cfg_error`; `bitfile` keeps its prior value; FSM returns to HUNT.
- Bits 1,0,1 followed by frame A5, 3C, 1F -> sliding window locks on A5; `bitfile`=8'h3C.
- A5, then 4 payload bits, then a 63-cycle idle gap, then the rest of a good frame -> commits. Repeating with a 64-cycle gap -> `cfg_error` on the 64th idle cycle; a subsequent good frame still commits.
- Good frame loading 8'h1B, then `reset` low for 1 cycle midway through a second frame -> `bitfile` immediately 8'h00 and `cfg_valid`=0; the next full good frame commits normally.
